multicycle_controller: RTL
==========================

# multicycle_controller

Main control FSM for the multicycle MIPS datapath. Sits directly upstream of the datapath components (ALU, register file, unified memory, PC/IR registers, datapath muxes). Each cycle it decodes the instruction register's opcode/funct plus the ALU zero flag and drives every enable, mux select and ALU operation code. The encodings match the datapath's ALU codes and mux port orderings.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  IR[31:26], stable except while ir_write=1
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag of the current cycle
- pc_write  output  1  PC load; already combines unconditional and branch-conditional writes
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- reg_dst  output  2  write register: 00=rt, 01=rd, 10=$31
- mem_to_reg  output  2  write data: 00=ALUOut, 01=MDR, 10=PC
- reg_write  output  1  register file write
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=const 4, 10=SE(imm), 11=SE(imm)<<2
- alu_operation  output  3  000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT
- pc_source  output  2  00=ALU result, 01=ALUOut, 10={PC[31:28], target<<2}
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- halted  output  1  sticky; set on an illegal instruction
- state  output  4  current state, for debug

## Operation
- 4-bit state register with encoded states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JAL=12, JR=13, HALT=15.
- Default values for every output not listed for a state: all enables 0, all selects 0, alu_operation=ADD.
- FETCH: mem_read, ir_write, alu_src_b=01, ADD, pc_write=1. Next state is DECODE.
- DECODE: alu_src_b=11, ADD (computes the branch target into ALUOut). Next state by opcode:
  - 100011 lw / 101011 sw → MEM_ADDR
  - 000000 → R_EXEC if funct ∈ {100000, 100010, 100100, 100101, 101010}; JR if funct=001000; otherwise HALT
  - 000100 beq / 000101 bne → BRANCH
  - 001000 addi / 001010 slti → I_EXEC
  - 000010 j → JUMP
  - 000011 jal → JAL
  - any other opcode → HALT
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: i_or_d=1, mem_read. Next state is MEM_WB.
- MEM_WB: reg_dst=00, mem_to_reg=01, reg_write, done.
- MEM_WRITE: i_or_d=1, mem_write, done.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_operation by funct: 100000→ADD, 100010→SUB, 100100→AND, 100101→OR, 101010→SLT.
- R_WB: reg_dst=01, reg_write, done.
- BRANCH: alu_src_a=1, SUB, pc_source=01. pc_write=zero for beq, pc_write=~zero for bne. done.
- I_EXEC: alu_src_a=1, alu_src_b=10. ADD for addi, SLT for slti.
- I_WB: reg_dst=00, reg_write, done.
- JUMP: pc_source=10, pc_write, done.
- JAL: reg_dst=10, mem_to_reg=10, reg_write, pc_source=10, pc_write, done. PC already holds PC+4, so $31 receives the return address.
- JR: alu_src_a=1, alu_src_b=00, ADD, pc_write. The encoding guarantees rt=$0, so the ALU result equals A. done.
- Every "done" state asserts instr_done and returns to FETCH.
- HALT: all enables 0, halted=1. The FSM stays in HALT until reset.

## Timing
- While rst_n=0: state=FETCH, halted=0, and every enable plus instr_done is forced to 0 asynchronously. The first FETCH cycle begins at the first clk edge after rst_n rises.
- Outputs are combinational from the state, opcode, funct and zero. Only pc_write in BRANCH depends on zero in the same cycle.
- Cycles per instruction: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3.
- rst_n asserted mid-instruction: the instruction is abandoned, no further writes occur, and the FSM restarts at FETCH.

## Configuration
- CTRL_JAL_JR_EN defined: the JAL and JR states exist and behave as described above.
- CTRL_JAL_JR_EN undefined: opcode 000011 and R-type funct 001000 decode to HALT. reg_dst and mem_to_reg never drive 10.

## Test plan
- Reset, then `add` (opcode 0, funct 100000): state sequence 0,1,6,7,0. alu_operation=010 in R_EXEC. reg_dst=01 and reg_write=1 in R_WB. instr_done high for exactly 1 cycle.
- `lw` followed by `sw`: lw takes 5 cycles with i_or_d=1 and mem_read=1 in MEM_READ and mem_to_reg=01 in MEM_WB. sw takes 4 cycles with mem_write=1 only in MEM_WRITE.
- `beq` with zero=1 gives pc_write=1 and pc_source=01. `beq` with zero=0 gives pc_write=0. `bne` gives the inverse result in each case.
- `jal`, then `jr`, both with CTRL_JAL_JR_EN defined: JAL drives reg_dst=10, mem_to_reg=10 and pc_source=10 with pc_write=1. JR drives alu_src_a=1, pc_source=00 and pc_write=1. Each takes 3 cycles.
- Opcode 111111 (also `jal` with the macro undefined): DECODE → HALT, halted=1, no enables for 10 cycles. Pulsing rst_n low returns state=0 and halted=0.
- Assert rst_n low during MEM_WRITE: mem_write drops immediately, state=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_write;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_operation;
   logic [1:0] pc_source;
   logic       instr_done;
   logic       halted;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero,
      output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_operation,
             pc_source, instr_done, halted, state
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_operation,
             pc_source, instr_done, halted, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath.
// Define CTRL_JAL_JR_EN to add the jal/jr states; otherwise both decode as illegal.
module multicycle_controller (
   input  logic                           clk,
   input  logic                           rst_n,
   multicycle_controller_if.master        bus
);

   localparam logic [3:0] FETCH     = 4'd0;
   localparam logic [3:0] DECODE    = 4'd1;
   localparam logic [3:0] MEM_ADDR  = 4'd2;
   localparam logic [3:0] MEM_READ  = 4'd3;
   localparam logic [3:0] MEM_WB    = 4'd4;
   localparam logic [3:0] MEM_WRITE = 4'd5;
   localparam logic [3:0] R_EXEC    = 4'd6;
   localparam logic [3:0] R_WB      = 4'd7;
   localparam logic [3:0] BRANCH    = 4'd8;
   localparam logic [3:0] JUMP      = 4'd9;
   localparam logic [3:0] I_EXEC    = 4'd10;
   localparam logic [3:0] I_WB      = 4'd11;
   localparam logic [3:0] HALT      = 4'd15;
`ifdef CTRL_JAL_JR_EN
   localparam logic [3:0] JAL       = 4'd12;
   localparam logic [3:0] JR        = 4'd13;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] F_JR      = 6'b001000;
`endif

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [2:0] ALU_AND   = 3'b000;
   localparam logic [2:0] ALU_OR    = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b111;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic       r_started;
   logic       w_pc_write, w_mem_read, w_mem_write, w_ir_write, w_reg_write, w_done;
   logic       w_i_or_d, w_alu_src_a;
   logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_source;
   logic [2:0] w_alu_op, w_r_op;
   logic       w_r_legal;

   // r_started holds FETCH for the first edge after reset release and masks all
   // enables while in reset, so no write can leak out during or just after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= FETCH;
         r_started <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_started <= 1'b1;
      end
   end

   always_comb begin
      w_r_legal = 1'b1;
      w_r_op    = ALU_ADD;
      case (bus.funct)
         6'b100000: w_r_op = ALU_ADD;
         6'b100010: w_r_op = ALU_SUB;
         6'b100100: w_r_op = ALU_AND;
         6'b100101: w_r_op = ALU_OR;
         6'b101010: w_r_op = ALU_SLT;
         default:   w_r_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_next       = r_state;
      w_pc_write   = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_done       = 1'b0;
      w_i_or_d     = 1'b0;
      w_alu_src_a  = 1'b0;
      w_reg_dst    = 2'b00;
      w_mem_to_reg = 2'b00;
      w_alu_src_b  = 2'b00;
      w_pc_source  = 2'b00;
      w_alu_op     = ALU_ADD;
      case (r_state)
         FETCH: begin
            w_mem_read  = 1'b1;
            w_ir_write  = 1'b1;
            w_alu_src_b = 2'b01;
            w_pc_write  = 1'b1;
            w_next      = r_started ? DECODE : FETCH;
         end
         DECODE: begin
            w_alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW:    w_next = MEM_ADDR;
               OP_BEQ, OP_BNE:  w_next = BRANCH;
               OP_ADDI, OP_SLTI: w_next = I_EXEC;
               OP_J:            w_next = JUMP;
`ifdef CTRL_JAL_JR_EN
               OP_JAL:          w_next = JAL;
`endif
               OP_RTYPE: begin
                  w_next = w_r_legal ? R_EXEC : HALT;
`ifdef CTRL_JAL_JR_EN
                  if (bus.funct == F_JR) w_next = JR;
`endif
               end
               default:         w_next = HALT;
            endcase
         end
         MEM_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_next      = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            w_i_or_d   = 1'b1;
            w_mem_read = 1'b1;
            w_next     = MEM_WB;
         end
         MEM_WB: begin
            w_mem_to_reg = 2'b01;
            w_reg_write  = 1'b1;
            w_done       = 1'b1;
            w_next       = FETCH;
         end
         MEM_WRITE: begin
            w_i_or_d    = 1'b1;
            w_mem_write = 1'b1;
            w_done      = 1'b1;
            w_next      = FETCH;
         end
         R_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = w_r_op;
            w_next      = R_WB;
         end
         R_WB: begin
            w_reg_dst   = 2'b01;
            w_reg_write = 1'b1;
            w_done      = 1'b1;
            w_next      = FETCH;
         end
         BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_SUB;
            w_pc_source = 2'b01;
            w_pc_write  = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
            w_done      = 1'b1;
            w_next      = FETCH;
         end
         I_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            w_next      = I_WB;
         end
         I_WB: begin
            w_reg_write = 1'b1;
            w_done      = 1'b1;
            w_next      = FETCH;
         end
         JUMP: begin
            w_pc_source = 2'b10;
            w_pc_write  = 1'b1;
            w_done      = 1'b1;
            w_next      = FETCH;
         end
`ifdef CTRL_JAL_JR_EN
         JAL: begin
            w_reg_dst    = 2'b10;
            w_mem_to_reg = 2'b10;
            w_reg_write  = 1'b1;
            w_pc_source  = 2'b10;
            w_pc_write   = 1'b1;
            w_done       = 1'b1;
            w_next       = FETCH;
         end
         JR: begin
            w_alu_src_a = 1'b1;
            w_pc_write  = 1'b1;
            w_done      = 1'b1;
            w_next      = FETCH;
         end
`endif
         default: w_next = HALT;
      endcase
   end

   assign bus.pc_write      = w_pc_write  & r_started;
   assign bus.mem_read      = w_mem_read  & r_started;
   assign bus.mem_write     = w_mem_write & r_started;
   assign bus.ir_write      = w_ir_write  & r_started;
   assign bus.reg_write     = w_reg_write & r_started;
   assign bus.instr_done    = w_done      & r_started;
   assign bus.i_or_d        = w_i_or_d;
   assign bus.alu_src_a     = w_alu_src_a;
   assign bus.reg_dst       = w_reg_dst;
   assign bus.mem_to_reg    = w_mem_to_reg;
   assign bus.alu_src_b     = w_alu_src_b;
   assign bus.pc_source     = w_pc_source;
   assign bus.alu_operation = w_alu_op;
   assign bus.halted        = (r_state == HALT);
   assign bus.state         = r_state;

endmodule
